// File: rtl/snooping.sv
// snooping: three-CPU MSI snooping-coherence model.
//   Each CPU owns a 4-line cache (status/tag/data per line). One shared bus
//   message and an 8x16 backing memory (instance "mem"). Every request takes
//   five clocks, T0..T4, and inputs are held for all five.
// Ports:
//   clock        in   1  system clock, posedge active
//   reset_n      in   1  asynchronous active-low reset
//   proc_num     in   2  requesting CPU 0..2, 3 = no-op transaction
//   m_tag        in   3  memory block address
//   tag_position in   2  line index in the requester's cache
//   op           in   1  0 write, 1 read
//   data         in  16  write data

// snooping_mem: single-port 8x16 memory, combinational read, posedge write.
//   enable/w_enable in 1, m_tag in 3, data_in in 16, data_out out 16.
module snooping_mem (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        w_enable,
   input  logic [2:0]  m_tag,
   input  logic [15:0] data_in,
   output logic [15:0] data_out
);
   logic [15:0] datas [0:7];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) datas[i] <= 16'(i * 10);
      end else if (enable && w_enable) begin
         datas[m_tag] <= data_in;
      end
   end

   assign data_out = datas[m_tag];
endmodule

// Transaction step sequencer (Tstep_Q):
//   state | meaning
//   T0    | look up requester line, publish bus message
//   T1    | write back a modified victim on a miss
//   T2    | other CPUs snoop; modified owner flushes to memory
//   T3    | memory read of m_tag on a miss
//   T4    | update requester line, clear bus message
module snooping (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  proc_num,
   input  logic [2:0]  m_tag,
   input  logic [1:0]  tag_position,
   input  logic        op,
   input  logic [15:0] data
);
   localparam logic [1:0] I = 2'b00, S = 2'b01, M = 2'b10;
   localparam logic WRITE = 1'b0, READ = 1'b1;
   localparam logic [1:0] NONE = 2'b00, RD_MISS = 2'b01, WR_MISS = 2'b10, INVAL = 2'b11;

   logic [2:0]  Tstep_Q, tstep_d;
   logic [1:0]  message, message_d;
   logic [2:0]  proc_tags   [0:2][0:3];
   logic [1:0]  proc_status [0:2][0:3];
   logic [15:0] proc_datas  [0:2][0:3];
   logic [2:0]  proc_tags_d   [0:2][0:3];
   logic [1:0]  proc_status_d [0:2][0:3];
   logic [15:0] proc_datas_d  [0:2][0:3];

   logic        mem_en, mem_wen;
   logic [2:0]  mem_addr;
   logic [15:0] mem_din, mem_dout;

   logic        active, hit, miss, snp_found;
   logic [1:0]  p_idx, req_status, snp_p, snp_l;
   logic [2:0]  req_tag;
   logic [15:0] req_data;

   snooping_mem mem (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (mem_en),
      .w_enable (mem_wen),
      .m_tag    (mem_addr),
      .data_in  (mem_din),
      .data_out (mem_dout)
   );

   assign active     = (proc_num != 2'd3);
   assign p_idx      = active ? proc_num : 2'd0;
   assign req_status = proc_status[p_idx][tag_position];
   assign req_tag    = proc_tags[p_idx][tag_position];
   assign req_data   = proc_datas[p_idx][tag_position];
   assign hit        = (req_status != I) && (req_tag == m_tag);
   // The requester's own line is untouched until T4, so the registered
   // message is enough to remember whether T0 saw a miss.
   assign miss       = (message == RD_MISS) || (message == WR_MISS);

   // First modified copy of m_tag held by another CPU; MSI allows only one.
   always_comb begin
      snp_found = 1'b0;
      snp_p     = 2'd0;
      snp_l     = 2'd0;
      for (int p = 0; p < 3; p++) begin
         for (int l = 0; l < 4; l++) begin
            if (!snp_found && (2'(p) != proc_num) && (proc_status[p][l] == M) &&
                (proc_tags[p][l] == m_tag)) begin
               snp_found = 1'b1;
               snp_p     = 2'(p);
               snp_l     = 2'(l);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         Tstep_Q <= 3'd0;
         message <= NONE;
         for (int p = 0; p < 3; p++) begin
            for (int l = 0; l < 4; l++) begin
               proc_tags[p][l]   <= 3'd0;
               proc_status[p][l] <= I;
               proc_datas[p][l]  <= 16'd0;
            end
         end
      end else begin
         Tstep_Q     <= tstep_d;
         message     <= message_d;
         proc_tags   <= proc_tags_d;
         proc_status <= proc_status_d;
         proc_datas  <= proc_datas_d;
      end
   end

   always_comb begin
      tstep_d = (Tstep_Q >= 3'd4) ? 3'd0 : Tstep_Q + 3'd1;
   end

   always_comb begin
      message_d     = message;
      proc_tags_d   = proc_tags;
      proc_status_d = proc_status;
      proc_datas_d  = proc_datas;
      mem_en        = 1'b0;
      mem_wen       = 1'b0;
      mem_addr      = m_tag;
      mem_din       = 16'd0;
      case (Tstep_Q)
         3'd0: begin
            if (active) begin
               if (op == READ)  message_d = hit ? NONE : RD_MISS;
               else if (!hit)   message_d = WR_MISS;
               else             message_d = (req_status == S) ? INVAL : NONE;
            end
         end
         3'd1: begin
            if (active && miss && (req_status == M) && (req_tag != m_tag)) begin
               mem_en   = 1'b1;
               mem_wen  = 1'b1;
               mem_addr = req_tag;
               mem_din  = req_data;
            end
         end
         3'd2: begin
            if (active && (message != NONE)) begin
               for (int p = 0; p < 3; p++) begin
                  for (int l = 0; l < 4; l++) begin
                     if ((2'(p) != proc_num) && (proc_status[p][l] != I) &&
                         (proc_tags[p][l] == m_tag)) begin
                        if (proc_status[p][l] == M) begin
                           if (message == RD_MISS)      proc_status_d[p][l] = S;
                           else if (message == WR_MISS) proc_status_d[p][l] = I;
                        end else if ((message == WR_MISS) || (message == INVAL)) begin
                           proc_status_d[p][l] = I;
                        end
                     end
                  end
               end
               if (snp_found && miss) begin
                  mem_en  = 1'b1;
                  mem_wen = 1'b1;
                  mem_din = proc_datas[snp_p][snp_l];
               end
            end
         end
         3'd3: begin
            if (active && miss) mem_en = 1'b1;
         end
         3'd4: begin
            if (active) begin
               if (op == WRITE) begin
                  proc_status_d[p_idx][tag_position] = M;
                  proc_tags_d[p_idx][tag_position]   = m_tag;
                  proc_datas_d[p_idx][tag_position]  = data;
               end else if (miss) begin
                  // Address still m_tag, so data_out holds the post-flush block.
                  proc_status_d[p_idx][tag_position] = S;
                  proc_tags_d[p_idx][tag_position]   = m_tag;
                  proc_datas_d[p_idx][tag_position]  = mem_dout;
               end
            end
            message_d = NONE;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_snooping.sv
`timescale 1ns/1ps
module tb_snooping;
   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  proc_num;
   logic [2:0]  m_tag;
   logic [1:0]  tag_position;
   logic        op;
   logic [15:0] data;

   snooping dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .proc_num     (proc_num),
      .m_tag        (m_tag),
      .tag_position (tag_position),
      .op           (op),
      .data         (data)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  pn;
      logic [2:0]  tag;
      logic [1:0]  pos;
      logic        op;
      logic [15:0] d;
      logic [1:0]  msg;
      int          lp;
      int          ll;
      logic [1:0]  lst;
      logic [2:0]  ltag;
      logic [15:0] ldat;
      int          opp;
      int          oll;
      logic [1:0]  ost;
      int          maddr;
      logic [15:0] mval;
   } vec_t;

   vec_t vecs [0:11];
   vec_t sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tagname);
      chk({tagname, " tstep"}, 32'(dut.Tstep_Q), 32'd0);
      chk({tagname, " message"}, 32'(dut.message), 32'd0);
      chk({tagname, " mem_en"}, 32'(dut.mem.enable), 32'd0);
      chk({tagname, " mem_wen"}, 32'(dut.mem.w_enable), 32'd0);
      for (int p = 0; p < 3; p++) begin
         for (int l = 0; l < 4; l++) begin
            chk($sformatf("%s st[%0d][%0d]", tagname, p, l), 32'(dut.proc_status[p][l]), 32'd0);
            chk($sformatf("%s tag[%0d][%0d]", tagname, p, l), 32'(dut.proc_tags[p][l]), 32'd0);
            chk($sformatf("%s dat[%0d][%0d]", tagname, p, l), 32'(dut.proc_datas[p][l]), 32'd0);
         end
      end
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s mem[%0d]", tagname, i), 32'(dut.mem.datas[i]), 32'(i * 10));
   endtask

   // Drive one transaction at a negedge with Tstep_Q==0; leaves at the next such point.
   task automatic run_txn(input vec_t v, input int idx);
      vec_t e;
      logic [1:0] got_msg;
      proc_num     = v.pn;
      m_tag        = v.tag;
      tag_position = v.pos;
      op           = v.op;
      data         = v.d;
      sb_q.push_back(v);
      got_msg = 2'd0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("v%0d tstep%0d", idx, k), 32'(dut.Tstep_Q), 32'(k));
         @(posedge clock);
         @(negedge clock);
         if (k == 0) got_msg = dut.message;
      end
      e = sb_q.pop_front();
      chk($sformatf("v%0d msg", idx), 32'(got_msg), 32'(e.msg));
      chk($sformatf("v%0d msg_clr", idx), 32'(dut.message), 32'd0);
      chk($sformatf("v%0d line_st", idx), 32'(dut.proc_status[e.lp][e.ll]), 32'(e.lst));
      chk($sformatf("v%0d line_tag", idx), 32'(dut.proc_tags[e.lp][e.ll]), 32'(e.ltag));
      chk($sformatf("v%0d line_dat", idx), 32'(dut.proc_datas[e.lp][e.ll]), 32'(e.ldat));
      chk($sformatf("v%0d other_st", idx), 32'(dut.proc_status[e.opp][e.oll]), 32'(e.ost));
      chk($sformatf("v%0d mem", idx), 32'(dut.mem.datas[e.maddr]), 32'(e.mval));
   endtask

   initial begin
      //          pn    tag   pos   op    d       msg    lp ll lst   ltag  ldat     opp oll ost  maddr mval
      vecs[0]  = '{2'd0, 3'd2, 2'd2, 1'b1, 16'd0,  2'd1, 0, 2, 2'd1, 3'd2, 16'd20,  1, 2, 2'd0, 2, 16'd20};
      vecs[1]  = '{2'd0, 3'd2, 2'd2, 1'b0, 16'd80, 2'd3, 0, 2, 2'd2, 3'd2, 16'd80,  2, 2, 2'd0, 2, 16'd20};
      vecs[2]  = '{2'd2, 3'd2, 2'd2, 1'b0, 16'd80, 2'd2, 2, 2, 2'd2, 3'd2, 16'd80,  0, 2, 2'd0, 2, 16'd80};
      vecs[3]  = '{2'd2, 3'd7, 2'd1, 1'b1, 16'd0,  2'd1, 2, 1, 2'd1, 3'd7, 16'd70,  0, 2, 2'd0, 7, 16'd70};
      vecs[4]  = '{2'd2, 3'd7, 2'd1, 1'b0, 16'd71, 2'd3, 2, 1, 2'd2, 3'd7, 16'd71,  1, 1, 2'd0, 7, 16'd70};
      vecs[5]  = '{2'd1, 3'd7, 2'd1, 1'b0, 16'd99, 2'd2, 1, 1, 2'd2, 3'd7, 16'd99,  2, 1, 2'd0, 7, 16'd71};
      vecs[6]  = '{2'd0, 3'd2, 2'd2, 1'b1, 16'd0,  2'd1, 0, 2, 2'd1, 3'd2, 16'd80,  2, 2, 2'd1, 2, 16'd80};
      vecs[7]  = '{2'd3, 3'd2, 2'd2, 1'b0, 16'd9,  2'd0, 0, 2, 2'd1, 3'd2, 16'd80,  2, 2, 2'd1, 2, 16'd80};
      vecs[8]  = '{2'd0, 3'd2, 2'd2, 1'b1, 16'd0,  2'd0, 0, 2, 2'd1, 3'd2, 16'd80,  2, 2, 2'd1, 2, 16'd80};
      vecs[9]  = '{2'd2, 3'd2, 2'd2, 1'b0, 16'd55, 2'd3, 2, 2, 2'd2, 3'd2, 16'd55,  0, 2, 2'd0, 2, 16'd80};
      vecs[10] = '{2'd2, 3'd2, 2'd2, 1'b0, 16'd56, 2'd0, 2, 2, 2'd2, 3'd2, 16'd56,  0, 2, 2'd0, 2, 16'd80};
      vecs[11] = '{2'd1, 3'd5, 2'd0, 1'b1, 16'd0,  2'd1, 1, 0, 2'd1, 3'd5, 16'd50,  1, 1, 2'd2, 5, 16'd50};

      reset_n      = 1'b0;
      proc_num     = 2'd3;
      m_tag        = 3'd0;
      tag_position = 2'd0;
      op           = 1'b1;
      data         = 16'd0;
      @(negedge clock);
      check_reset_state("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

      // Victim writeback at T1, then reset during T2 discards the rest.
      proc_num     = 2'd1;
      m_tag        = 3'd3;
      tag_position = 2'd1;
      op           = 1'b1;
      data         = 16'd0;
      @(posedge clock);
      @(negedge clock);
      chk("wb msg", 32'(dut.message), 32'd1);
      chk("wb tstep1", 32'(dut.Tstep_Q), 32'd1);
      @(posedge clock);
      @(negedge clock);
      chk("wb tstep2", 32'(dut.Tstep_Q), 32'd2);
      chk("wb mem7", 32'(dut.mem.datas[7]), 32'd99);
      chk("wb line kept", 32'(dut.proc_status[1][1]), 32'd2);
      reset_n = 1'b0;
      #1;
      check_reset_state("midreset");
      @(negedge clock);
      check_reset_state("midreset_hold");
      reset_n = 1'b1;

      begin
         vec_t v;
         v = '{2'd0, 3'd3, 2'd0, 1'b1, 16'd0, 2'd1, 0, 0, 2'd1, 3'd3, 16'd30, 0, 2, 2'd0, 3, 16'd30};
         run_txn(v, 12);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
